// File: rtl/assoc_cache.sv
// Set-associative, write-through, no-write-allocate data cache with multi-word
// line refill over a simple request/ready memory port.
module assoc_cache #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SETS           = 16,
   parameter int WAYS           = 2,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  cpu_read,
   input  logic                  cpu_write,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_ready,
   output logic                  hit,
   output logic                  miss,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_ready
);
   localparam int WOFF_W  = $clog2(WORDS_PER_LINE);
   localparam int IDX_W   = $clog2(SETS);
   localparam int IDX_LSB = 2 + WOFF_W;
   localparam int TAG_LSB = IDX_LSB + IDX_W;
   localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;
   localparam int CNT_W   = (WOFF_W > 0) ? WOFF_W : 1;
   localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(WORDS_PER_LINE * 4 - 1);

   typedef enum logic [1:0] {IDLE, REFILL, WRITE, RESP} state_t;

   logic [DATA_WIDTH-1:0]           data_arr [SETS][WAYS][WORDS_PER_LINE];
   logic [TAG_W-1:0]                tag_arr  [SETS][WAYS];
   logic [SETS-1:0][WAYS-1:0]       valid;
   logic [SETS-1:0][WAY_W-1:0]      ptr;

   state_t                state, state_d;
   logic [IDX_W-1:0]      cur_idx, req_idx;
   logic [TAG_W-1:0]      cur_tag;
   logic [CNT_W-1:0]      cur_woff, req_woff, cnt;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [WAYS-1:0]       way_hit;
   logic [WAY_W-1:0]      hit_way, inv_way, victim, way_q;
   logic                  any_hit, any_inv, hit_q, vict_valid_q, last_word;

   assign cur_idx = cpu_addr[TAG_LSB-1:IDX_LSB];
   assign cur_tag = cpu_addr[ADDR_WIDTH-1:TAG_LSB];
   assign req_idx = req_addr[TAG_LSB-1:IDX_LSB];

   generate
      if (WOFF_W > 0) begin : g_woff
         assign cur_woff = cpu_addr[IDX_LSB-1:2];
      end else begin : g_nowoff
         assign cur_woff = '0;
      end
      for (genvar w = 0; w < WAYS; w++) begin : g_way
         assign way_hit[w] = valid[cur_idx][w] && (tag_arr[cur_idx][w] == cur_tag);
      end
   endgenerate

   // Descending scan so the lowest-numbered matching/invalid way wins.
   always_comb begin
      hit_way = '0;
      inv_way = '0;
      any_inv = 1'b0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (way_hit[WAY_W'(w)]) hit_way = WAY_W'(w);
         if (!valid[cur_idx][WAY_W'(w)]) begin
            inv_way = WAY_W'(w);
            any_inv = 1'b1;
         end
      end
      any_hit = |way_hit;
      victim  = any_inv ? inv_way : ((WAYS > 1) ? ptr[cur_idx] : '0);
   end

   assign last_word = (cnt == CNT_W'(WORDS_PER_LINE - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (cpu_write)     state_d = WRITE;
                  else if (cpu_read) state_d = any_hit ? RESP : REFILL;
         REFILL:  if (mem_ready && last_word) state_d = RESP;
         WRITE:   if (mem_ready) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid        <= '0;
         ptr          <= '0;
         cnt          <= '0;
         req_addr     <= '0;
         req_woff     <= '0;
         req_wdata    <= '0;
         way_q        <= '0;
         hit_q        <= 1'b0;
         vict_valid_q <= 1'b0;
         cpu_rdata    <= '0;
      end else begin
         case (state)
            IDLE: if (cpu_write || cpu_read) begin
               req_addr     <= cpu_addr & ~ADDR_WIDTH'(3);
               req_woff     <= cur_woff;
               req_wdata    <= cpu_wdata;
               hit_q        <= any_hit;
               cnt          <= '0;
               way_q        <= (cpu_write || any_hit) ? hit_way : victim;
               vict_valid_q <= !any_inv;
               if (!cpu_write && any_hit)
                  cpu_rdata <= data_arr[cur_idx][hit_way][cur_woff];
            end
            REFILL: if (mem_ready) begin
               cnt <= cnt + 1'b1;
               if (cnt == req_woff) cpu_rdata <= mem_rdata;
               // Line becomes visible only once every word has landed.
               if (last_word) begin
                  valid[req_idx][way_q] <= 1'b1;
                  if (WAYS > 1 && vict_valid_q) ptr[req_idx] <= ptr[req_idx] + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == REFILL && mem_ready) begin
         data_arr[req_idx][way_q][cnt] <= mem_rdata;
         if (last_word) tag_arr[req_idx][way_q] <= req_addr[ADDR_WIDTH-1:TAG_LSB];
      end
      if (state == WRITE && mem_ready && hit_q)
         data_arr[req_idx][way_q][req_woff] <= req_wdata;
   end

   assign cpu_ready = (state == RESP);
   assign hit       = cpu_ready & hit_q;
   assign miss      = cpu_ready & ~hit_q;
   assign mem_read  = (state == REFILL);
   assign mem_write = (state == WRITE);
   assign mem_wdata = (state == WRITE) ? req_wdata : '0;

   always_comb begin
      mem_addr = '0;
      if (state == REFILL)     mem_addr = (req_addr & ~LINE_MASK) | (ADDR_WIDTH'(cnt) << 2);
      else if (state == WRITE) mem_addr = req_addr;
   end
endmodule

// File: tb/tb_assoc_cache.sv
// Bench for assoc_cache: directed scenarios plus random traffic checked against
// a cache-occupancy model and a flat backing memory.
module tb_assoc_cache;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_read = 1'b0, cpu_write = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic [31:0] cpu_rdata, mem_addr, mem_wdata;
   logic        cpu_ready, hit, miss, mem_read, mem_write;
   logic [31:0] mem_rdata = '0;
   logic        mem_ready = 1'b0;

   assoc_cache dut (
      .clk(clk), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
      .cpu_ready(cpu_ready), .hit(hit), .miss(miss), .mem_read(mem_read),
      .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   typedef struct { bit wr; logic [31:0] addr; logic [31:0] data; } mem_op_t;
   typedef struct { bit hit; bit rd; logic [31:0] data; } rsp_t;

   // Model: 16 sets x 2 ways of {valid, tag}, a round-robin pointer per set,
   // and a sparse backing memory whose untouched words hold {C0DE, addr[15:0]}.
   bit          m_valid [16][2];
   logic [23:0] m_tag   [16][2];
   int          m_ptr   [16];
   logic [31:0] mem_arr [logic [31:0]];
   mem_op_t     exp_mem_q[$];
   rsp_t        exp_rsp_q[$];
   logic [31:0] seen_q[$];
   int errors = 0, checks = 0, hs_cnt = 0, lat_lo = 0, lat_hi = 0, wait_cnt = 0;

   function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
      end
   endfunction

   function automatic logic [31:0] mem_val(logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return {16'hC0DE, a[15:0]};
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < 16; s++) begin
         m_ptr[s] = 0;
         for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
      end
      exp_mem_q.delete();
      exp_rsp_q.delete();
   endfunction

   function automatic bit model_access(bit wr, logic [31:0] a, logic [31:0] wd);
      logic [31:0] aw;
      logic [23:0] t;
      int s, hw, v;
      aw = a & ~32'h3;
      s  = int'((aw / 16) % 16);
      t  = 24'(aw / 256);
      hw = -1;
      v  = -1;
      for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
      if (wr) begin
         exp_mem_q.push_back('{1'b1, aw, wd});
         exp_rsp_q.push_back('{hw >= 0, 1'b0, 32'h0});
      end else if (hw >= 0) begin
         exp_rsp_q.push_back('{1'b1, 1'b1, mem_val(aw)});
      end else begin
         for (int w = 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
         if (v < 0) begin
            v = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % 2;
         end
         for (int k = 0; k < 4; k++)
            exp_mem_q.push_back('{1'b0, (aw & ~32'hF) + 32'(4 * k), 32'h0});
         m_valid[s][v] = 1'b1;
         m_tag[s][v]   = t;
         exp_rsp_q.push_back('{1'b0, 1'b1, mem_val(aw)});
      end
      return hw >= 0;
   endfunction

   // Memory responder: decides a little after each rising edge.
   initial forever begin
      @(posedge clk);
      #2;
      if (!reset) begin
         mem_ready = 1'b0;
         wait_cnt  = $urandom_range(lat_hi, lat_lo);
      end else if (mem_ready) begin
         mem_ready = 1'b0;
         mem_rdata = $urandom;
         wait_cnt  = $urandom_range(lat_hi, lat_lo);
      end else if (!(mem_read || mem_write)) begin
         wait_cnt = $urandom_range(lat_hi, lat_lo);
      end else if (wait_cnt == 0) begin
         mem_ready = 1'b1;
         if (mem_read) mem_rdata = mem_val(mem_addr);
         else          mem_arr[mem_addr] = mem_wdata;
      end else begin
         wait_cnt--;
      end
   end

   // Compare process: every falling edge out of reset.
   initial forever begin
      rsp_t r;
      mem_op_t o;
      @(negedge clk);
      if (reset) begin
         checks++;
         if ((hit && miss) || (mem_read && mem_write) || (!cpu_ready && (hit || miss))) begin
            errors++;
            $display("FAIL flag_exclusivity: hit=%b miss=%b ready=%b mem_read=%b mem_write=%b, required exclusive and gated",
                     hit, miss, cpu_ready, mem_read, mem_write);
         end
         if (cpu_ready) begin
            if (exp_rsp_q.size() == 0) check("unexpected_cpu_ready", 32'd1, 32'd0);
            else begin
               r = exp_rsp_q.pop_front();
               check("rsp_hit", {31'b0, hit}, {31'b0, r.hit});
               check("rsp_miss", {31'b0, miss}, {31'b0, !r.hit});
               if (r.rd) check("rsp_rdata", cpu_rdata, r.data);
            end
         end
         if ((mem_read || mem_write) && mem_ready) begin
            hs_cnt++;
            seen_q.push_back(mem_addr);
            if (exp_mem_q.size() == 0) check("unexpected_mem_op", mem_addr, 32'hFFFF_FFFF);
            else begin
               o = exp_mem_q.pop_front();
               check("mem_kind", {31'b0, mem_write}, {31'b0, o.wr});
               check("mem_addr", mem_addr, o.addr);
               if (o.wr) check("mem_wdata", mem_wdata, o.data);
            end
         end
      end
   end

   task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         output bit rh, output bit rm, output logic [31:0] rd);
      bit eh;
      int cyc;
      eh = model_access(wr, a, wd);
      @(negedge clk);
      cpu_read = !wr; cpu_write = wr; cpu_addr = a; cpu_wdata = wd;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!cpu_ready && cyc < 400);
      rh = hit; rm = miss; rd = cpu_rdata;
      if (!cpu_ready) begin
         check("cpu_ready_timeout", 32'd0, 32'd1);
         exp_mem_q.delete();
         exp_rsp_q.delete();
      end else if (!wr && eh) begin
         check("hit_latency", 32'(cyc), 32'd1);
      end
      cpu_read = 1'b0; cpu_write = 1'b0;
      check("mem_q_drained", 32'(exp_mem_q.size()), 32'd0);
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      #3 reset = 1'b0;
      repeat (n) @(negedge clk);
      check("reset_flags", {27'b0, cpu_ready, hit, miss, mem_read, mem_write}, 32'd0);
      check("reset_data", cpu_rdata | mem_addr | mem_wdata, 32'd0);
      model_reset();
      reset = 1'b1;
   endtask

   task automatic check_refill(input logic [31:0] base);
      check("refill_count", 32'(seen_q.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         check("refill_addr", (seen_q.size() > k) ? seen_q[k] : 32'hFFFF_FFFF, base + 32'(4 * k));
   endtask

   initial begin
      bit rh, rm, eh;
      logic [31:0] rd, a;
      int cyc, base;
      #1 reset = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("post_reset_flags", {27'b0, cpu_ready, hit, miss, mem_read, mem_write}, 32'd0);
      check("post_reset_data", cpu_rdata | mem_addr | mem_wdata, 32'd0);

      lat_lo = 2; lat_hi = 2;
      seen_q.delete();
      do_req(0, 32'h108, 0, rh, rm, rd);
      check("miss_0x108", {30'b0, rh, rm}, 32'b01);
      check("data_0x108", rd, 32'hC0DE_0108);
      check_refill(32'h100);

      seen_q.delete();
      do_req(0, 32'h10C, 0, rh, rm, rd);
      check("hit_0x10C", {30'b0, rh, rm}, 32'b10);
      check("data_0x10C", rd, 32'hC0DE_010C);
      check("hit_no_mem", 32'(seen_q.size()), 32'd0);

      do_req(1, 32'h104, 32'hDEAD_BEEF, rh, rm, rd);
      check("whit_0x104", {30'b0, rh, rm}, 32'b10);
      check("mem_0x104", mem_val(32'h104), 32'hDEAD_BEEF);
      do_req(0, 32'h104, 0, rh, rm, rd);
      check("rhit_0x104", {30'b0, rh, rm}, 32'b10);
      check("data_0x104", rd, 32'hDEAD_BEEF);

      do_req(1, 32'h504, 32'h1234_5678, rh, rm, rd);
      check("wmiss_0x504", {30'b0, rh, rm}, 32'b01);
      do_req(0, 32'h504, 0, rh, rm, rd);
      check("rmiss_0x504", {30'b0, rh, rm}, 32'b01);
      check("data_0x504", rd, 32'h1234_5678);

      // Abandon a refill during its third word.
      eh = model_access(0, 32'h300, 0);
      @(negedge clk);
      cpu_read = 1'b1; cpu_addr = 32'h300;
      base = hs_cnt; cyc = 0;
      while ((hs_cnt - base < 2 || !mem_read || mem_ready) && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check("third_word_reached", {31'b0, cyc < 200}, 32'd1);
      #3 reset = 1'b0;
      #1 check("abort_mem_flags", {30'b0, mem_read, mem_write}, 32'd0);
      check("abort_mem_addr", mem_addr, 32'd0);
      cpu_read = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen_q.delete();
      do_req(0, 32'h300, 0, rh, rm, rd);
      check("rerefill_miss", {30'b0, rh, rm}, 32'b01);
      check_refill(32'h300);

      // Eviction in set 0 from a clean cache.
      do_reset(3);
      do_req(0, 32'h000, 0, rh, rm, rd);
      check("ev_0x000", {30'b0, rh, rm}, 32'b01);
      do_req(0, 32'h100, 0, rh, rm, rd);
      check("ev_0x100", {30'b0, rh, rm}, 32'b01);
      do_req(0, 32'h200, 0, rh, rm, rd);
      check("ev_0x200", {30'b0, rh, rm}, 32'b01);
      do_req(0, 32'h100, 0, rh, rm, rd);
      check("ev_rehit_0x100", {30'b0, rh, rm}, 32'b10);
      do_req(0, 32'h000, 0, rh, rm, rd);
      check("ev_remiss_0x000", {30'b0, rh, rm}, 32'b01);

      // Random traffic over a small footprint so lines collide and get reused.
      lat_lo = 0; lat_hi = 3;
      for (int i = 0; i < 400; i++) begin
         a = 32'($urandom_range(5) * 256 + $urandom_range(2) * 16 +
                 $urandom_range(3) * 4 + $urandom_range(3));
         do_req($urandom_range(9) < 3, a, $urandom, rh, rm, rd);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end
endmodule
